// File: rtl/ahb_rect_fill_ctrl.sv
// rtl/ahb_rect_fill_ctrl.sv - AHB-Lite rectangle-fill sequencer driving a req/gnt pixel write port
module ahb_rect_fill_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              pix_req,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_data,
  input  logic              pix_gnt,
  output logic              irq
);

  localparam int XW = 10;
  localparam int YW = 9;
  localparam logic [XW-1:0]     X_MAX  = XW'(H_RES - 1);
  localparam logic [YW-1:0]     Y_MAX  = YW'(V_RES - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_RES);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_FILL, ST_DONE} state_t;
  state_t state, state_nx;

  logic          dp_valid, dp_write;
  logic [2:0]    dp_addr;
  logic          irq_en, done, colour, colour_run;
  logic [XW-1:0] x0, x1, xa_q, xb_q, cur_x;
  logic [YW-1:0] y0, y1, yb_q, cur_y;
  logic [ADDR_W-1:0] row_base, count;

  logic unused_bits;
  assign unused_bits = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA[31:25], HWDATA[15:10]};

  // AHB address-phase capture; the data phase follows with zero wait states
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 3'd0;
    end else if (HREADY) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR[4:2];
    end
  end

  logic wr_en, wr_ctrl, wr_status, start_go, busy;
  assign wr_en     = dp_valid & dp_write;
  assign wr_ctrl   = wr_en && (dp_addr == 3'd0);
  assign wr_status = wr_en && (dp_addr == 3'd1);
  assign start_go  = wr_ctrl && HWDATA[0] && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // Geometry normalisation evaluated during SETUP
  logic [XW-1:0]     xa_c, xmax_c, xb_c;
  logic [YW-1:0]     ya_c, ymax_c, yb_c;
  logic [ADDR_W-1:0] row_base_c;
  logic              empty_c;

  always_comb begin
    xa_c       = (x0 < x1) ? x0 : x1;
    xmax_c     = (x0 < x1) ? x1 : x0;
    ya_c       = (y0 < y1) ? y0 : y1;
    ymax_c     = (y0 < y1) ? y1 : y0;
    xb_c       = (xmax_c > X_MAX) ? X_MAX : xmax_c;
    yb_c       = (ymax_c > Y_MAX) ? Y_MAX : ymax_c;
    empty_c    = (xa_c > X_MAX) || (ya_c > Y_MAX);
    row_base_c = ADDR_W'(ya_c) * STRIDE;
  end

  logic row_end, last_px;
  assign row_end = !(cur_x < xb_q);
  assign last_px = row_end && !(cur_y < yb_q);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start_go) state_nx = ST_SETUP;
      ST_SETUP: state_nx = empty_c ? ST_DONE : ST_FILL;
      ST_FILL:  if (pix_gnt && last_px) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      colour     <= 1'b0;
      colour_run <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      x1         <= '0;
      y1         <= '0;
      xa_q       <= '0;
      xb_q       <= '0;
      yb_q       <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      row_base   <= '0;
      count      <= '0;
    end else begin
      state <= state_nx;

      if (wr_ctrl) irq_en <= HWDATA[1];
      if (wr_en && dp_addr == 3'd2) begin
        x0 <= HWDATA[9:0];
        y0 <= HWDATA[24:16];
      end
      if (wr_en && dp_addr == 3'd3) begin
        x1 <= HWDATA[9:0];
        y1 <= HWDATA[24:16];
      end
      if (wr_en && dp_addr == 3'd4) colour <= HWDATA[0];

      // Completion set takes priority over a software clear in the same cycle
      if (state == ST_DONE)               done <= 1'b1;
      else if (start_go)                  done <= 1'b0;
      else if (wr_status && HWDATA[1])    done <= 1'b0;

      if (start_go) begin
        count      <= '0;
        colour_run <= colour;
      end else if (state == ST_FILL && pix_gnt) begin
        count <= count + 1'b1;
      end

      if (state == ST_SETUP) begin
        xa_q     <= xa_c;
        xb_q     <= xb_c;
        yb_q     <= yb_c;
        cur_x    <= xa_c;
        cur_y    <= ya_c;
        row_base <= row_base_c;
      end else if (state == ST_FILL && pix_gnt) begin
        if (!row_end) begin
          cur_x <= cur_x + 1'b1;
        end else if (cur_y < yb_q) begin
          cur_x    <= xa_q;
          cur_y    <= cur_y + 1'b1;
          row_base <= row_base + STRIDE;
        end
      end
    end
  end

  assign pix_req   = (state == ST_FILL);
  assign pix_addr  = pix_req ? (row_base + ADDR_W'(cur_x)) : '0;
  assign pix_data  = pix_req & colour_run;
  assign irq       = done & irq_en;
  assign HREADYOUT = 1'b1;

  always_comb begin
    HRDATA = 32'd0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        3'd0: HRDATA[1] = irq_en;
        3'd1: HRDATA[1:0] = {done, busy};
        3'd2: begin
          HRDATA[9:0]   = x0;
          HRDATA[24:16] = y0;
        end
        3'd3: begin
          HRDATA[9:0]   = x1;
          HRDATA[24:16] = y1;
        end
        3'd4: HRDATA[0] = colour;
        3'd5: HRDATA[ADDR_W-1:0] = count;
        default: HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_rect_fill_ctrl.sv
// tb/tb_ahb_rect_fill_ctrl.sv - self-checking bench for ahb_rect_fill_ctrl
module tb_ahb_rect_fill_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADYOUT, pix_req, pix_data, pix_gnt, irq;
  logic [18:0] pix_addr;

  int   checks = 0;
  int   errors = 0;
  bit   gnt_mode = 1'b0;
  int   got_a[$];
  logic got_d[$];
  int   exp_a[$];
  logic exp_col;

  ahb_rect_fill_ctrl #(.H_RES(640), .V_RES(480), .ADDR_W(19)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .pix_req(pix_req), .pix_addr(pix_addr),
    .pix_data(pix_data), .pix_gnt(pix_gnt), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pixel-port model: drives pix_gnt, records granted pixels, enforces hold-while-stalled
  initial begin
    logic        prev_req, prev_gnt, prev_d;
    logic [18:0] prev_addr;
    prev_req = 0; prev_gnt = 0; prev_d = 0; prev_addr = 0;
    pix_gnt = 1'b0;
    forever begin
      @(negedge HCLK);
      if (prev_req && !prev_gnt) begin
        check("hold_req", {31'd0, pix_req}, 32'd1);
        check("hold_addr", {13'd0, pix_addr}, {13'd0, prev_addr});
        check("hold_data", {31'd0, pix_data}, {31'd0, prev_d});
      end
      pix_gnt = gnt_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_req && pix_gnt && !HRESET) begin
        got_a.push_back(int'(pix_addr));
        got_d.push_back(pix_data);
      end
      prev_req = pix_req; prev_gnt = pix_gnt;
      prev_addr = pix_addr; prev_d = pix_data;
    end
  end

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = {27'd0, a};
    @(negedge HCLK);
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
    @(posedge HCLK);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = {27'd0, a};
    @(negedge HCLK);
    HSEL = 0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  function automatic void build_exp(int x0, int y0, int x1, int y1);
    int xa, xb, ya, yb;
    exp_a.delete();
    xa = (x0 < x1) ? x0 : x1;  xb = (x0 < x1) ? x1 : x0;
    ya = (y0 < y1) ? y0 : y1;  yb = (y0 < y1) ? y1 : y0;
    if (xb > 639) xb = 639;
    if (yb > 479) yb = 479;
    if (xa > 639 || ya > 479) return;
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++)
        exp_a.push_back(y * 640 + x);
  endfunction

  task automatic prog(input int x0, input int y0, input int x1, input int y1, input logic c);
    bus_write(5'h08, (y0 << 16) | x0);
    bus_write(5'h0C, (y1 << 16) | x1);
    bus_write(5'h10, {31'd0, c});
    build_exp(x0, y0, x1, y1);
    exp_col = c;
    got_a.delete();
    got_d.delete();
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int n;
    st = 32'd1; n = 0;
    while (st[0] && n < 3000) begin
      bus_read(5'h04, st);
      n++;
    end
    check("busy_timeout", {31'd0, st[0]}, 32'd0);
  endtask

  task automatic finish_fill(input string tag);
    logic [31:0] r;
    int n;
    wait_idle();
    check({tag, "_npix"}, got_a.size(), exp_a.size());
    n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, got_a[i], exp_a[i]);
      check({tag, "_data"}, {31'd0, got_d[i]}, {31'd0, exp_col});
    end
    bus_read(5'h14, r);
    check({tag, "_count"}, r, exp_a.size());
    bus_read(5'h04, r);
    check({tag, "_status"}, r, 32'd2);
  endtask

  initial begin
    logic [31:0] r;
    int x0, y0, x1, y1;
    HRESET = 1; HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HSIZE = 3'd2;
    HWDATA = 0; HREADY = 1;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_hrdata", HRDATA, 0);
    check("rst_hreadyout", {31'd0, HREADYOUT}, 1);
    check("rst_pix", {12'd0, pix_req, pix_data, irq, pix_addr}, 0);
    HRESET = 0;
    bus_read(5'h04, r); check("rst_status", r, 0);
    bus_read(5'h14, r); check("rst_count", r, 0);

    // Basic fill with cycle-exact start latency and interrupt timing
    bus_write(5'h00, 32'h2);
    prog(2, 1, 4, 2, 1'b1);
    gnt_mode = 0;
    bus_write(5'h00, 32'h3);
    @(negedge HCLK); check("setup_no_req", {31'd0, pix_req}, 0);
    @(negedge HCLK); check("first_req", {31'd0, pix_req}, 1);
    check("first_addr", {13'd0, pix_addr}, 642);
    check("first_data", {31'd0, pix_data}, 1);
    repeat (6) @(negedge HCLK);
    check("done_state_irq", {31'd0, irq}, 0);
    check("done_state_req", {31'd0, pix_req}, 0);
    @(negedge HCLK); check("irq_rise", {31'd0, irq}, 1);
    finish_fill("basic");
    bus_write(5'h04, 32'h2);
    @(negedge HCLK); check("irq_clear", {31'd0, irq}, 0);
    bus_read(5'h04, r); check("done_clear", r, 0);

    prog(4, 2, 2, 1, 1'b1);
    bus_write(5'h00, 32'h3);
    finish_fill("swap");

    prog(638, 478, 1000, 500, 1'b0);
    bus_write(5'h00, 32'h3);
    finish_fill("clip");

    prog(700, 10, 700, 10, 1'b1);
    bus_write(5'h00, 32'h3);
    @(negedge HCLK); check("empty_irq_e0", {31'd0, irq}, 0);
    @(negedge HCLK); check("empty_irq_e1", {31'd0, irq}, 0);
    @(negedge HCLK); check("empty_irq_e2", {31'd0, irq}, 1);
    finish_fill("empty");

    // Stalled grants, START and COLOUR writes while busy
    prog(5, 7, 14, 9, 1'b1);
    gnt_mode = 1;
    bus_write(5'h00, 32'h3);
    repeat (5) @(negedge HCLK);
    bus_write(5'h10, 32'h0);
    bus_write(5'h00, 32'h3);
    finish_fill("midfill");
    bus_read(5'h10, r); check("colour_reg", r, 0);

    for (int t = 0; t < 6; t++) begin
      x0 = $urandom_range(0, 700);
      y0 = $urandom_range(0, 490);
      x1 = x0 + $urandom_range(0, 6) - 3; if (x1 < 0) x1 = 0;
      y1 = y0 + $urandom_range(0, 6) - 3; if (y1 < 0) y1 = 0;
      gnt_mode = 1'($urandom_range(0, 1));
      prog(x0, y0, x1, y1, 1'($urandom_range(0, 1)));
      bus_write(5'h00, 32'h3);
      finish_fill("rand");
    end

    // Reset during FILL
    gnt_mode = 0;
    prog(0, 0, 20, 20, 1'b1);
    bus_write(5'h00, 32'h3);
    repeat (10) @(negedge HCLK);
    HRESET = 1;
    @(posedge HCLK);
    @(negedge HCLK);
    check("rstfill_req", {31'd0, pix_req}, 0);
    check("rstfill_irq", {31'd0, irq}, 0);
    HRESET = 0;
    x0 = got_a.size();
    repeat (20) @(negedge HCLK);
    check("rstfill_nomore", got_a.size(), x0);
    bus_read(5'h00, r); check("rstfill_ctrl", r, 0);
    bus_read(5'h04, r); check("rstfill_status", r, 0);
    bus_read(5'h08, r); check("rstfill_p0", r, 0);
    bus_read(5'h0C, r); check("rstfill_p1", r, 0);
    bus_read(5'h10, r); check("rstfill_colour", r, 0);
    bus_read(5'h14, r); check("rstfill_count", r, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_rect_fill_ctrl.md
# ahb_rect_fill_ctrl

AHB-Lite slave that sequences rectangle-fill operations into the pixel frame buffer for the M0 SoC. The CPU programs two corner coordinates and a colour, then writes START. The block then walks the rectangle row by row and issues single-pixel write requests on a req/gnt port. That port is shared with the pixel memory's write side. The block gives software a hardware fill primitive, so the CPU no longer performs per-pixel AHB stores.

## Interface
Parameters:
- H_RES, 640, visible pixels per row; also the row stride of the frame buffer address.
- V_RES, 480, visible rows.
- ADDR_W, 19, pixel address width (ceil(log2(H_RES*V_RES))).

Ports:
- HCLK  in  1  system clock; the single clock for the whole block.
- HRESET  in  1  reset, synchronous, active-high.
- HSEL  in  1  slave select from interconnect.
- HADDR  in  32  AHB address; only bits [4:2] are decoded.
- HTRANS  in  2  transfer type; bit 1 set means a valid transfer.
- HWRITE  in  1  write, not read.
- HSIZE  in  3  ignored; all accesses are treated as 32-bit.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready; qualifies address-phase capture.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  constant 1 (zero wait states).
- pix_req  out  1  pixel write request.
- pix_addr  out  ADDR_W  linear pixel address, y*H_RES+x.
- pix_data  out  1  pixel value to write.
- pix_gnt  in  1  pixel memory accepts the current request this cycle.
- irq  out  1  level interrupt: DONE & IRQ_EN.

## Operation
- Address-phase capture: HSEL & HTRANS[1] & HREADY registers the write flag and HADDR[4:2] at the clock edge. Writes take effect at the edge that ends the data phase.
- Register map (word offsets):
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN (R/W).
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (sticky; write 1 to clear).
  - 0x08 P0: x0 in [9:0], y0 in [24:16].
  - 0x0C P1: x1 in [9:0], y1 in [24:16].
  - 0x10 COLOUR: bit0.
  - 0x14 COUNT: RO pixels written by the last or current fill, 19 bits.
  - Unused offsets read 0; writes to them are ignored.
- HRDATA is driven from the registered address during the data phase. A read issued the cycle after a write to the same register returns the new value.
- FSM states and transitions:
  - IDLE: a START write moves to SETUP. The same write also clears DONE and COUNT.
  - SETUP (1 cycle): latch the geometry.
    - xa=min(x0,x1), xb=max(x0,x1); ya, yb likewise.
    - Clamp xb to H_RES-1 and yb to V_RES-1.
    - If xa>H_RES-1 or ya>V_RES-1, the rectangle is empty: go to DONE.
    - Otherwise load cur_x=xa, cur_y=ya, row_base=ya*H_RES. The multiply is computed once; shift-add is acceptable.
  - FILL: pix_req=1, pix_addr=row_base+cur_x, pix_data=COLOUR latched at START.
    - On pix_gnt, COUNT increments, then:
    - If cur_x<xb: cur_x+1.
    - Else if cur_y<yb: cur_x=xa, cur_y+1, row_base+=H_RES.
    - Else go to DONE.
  - DONE (1 cycle): set DONE, then go to IDLE.
- BUSY=1 in SETUP, FILL and DONE.
- START while BUSY is ignored. Writes to P0, P1 and COLOUR while BUSY update the registers but do not affect the running fill.
- When pix_gnt=0, pix_req, pix_addr and pix_data hold stable.
- A DONE clear and DONE set in the same cycle: the set wins.

## Timing
- Reset values: all registers 0, state IDLE, pix_req=0, pix_addr=0, pix_data=0, HRDATA=0, irq=0, HREADYOUT=1.
- Reset asserted mid-fill: the next edge returns to IDLE, pix_req drops, and no further pixels are written.
- START data phase ends at edge E. SETUP runs in cycle E..E+1. pix_req is first high after edge E+1.
- With pix_gnt held high, throughput is 1 pixel per cycle. A W×H fill keeps BUSY high for W*H+2 cycles.
- DONE and irq rise at the edge after the last grant plus 1 cycle (the DONE state). BUSY falls at the same edge.

## Test plan
- Fill (2,1)-(4,2) with colour 1, pix_gnt=1: exactly 6 requests, addrs 642,643,644,1282,1283,1284. Then COUNT=6, DONE=1, BUSY=0.
- Swapped corners P0=(4,2), P1=(2,1): identical 6-address sequence. Clipping P0=(638,478), P1=(1000,500): addrs 306558,306559,307198,307199 only.
- Empty rectangle P0=P1=(700,10): no pix_req. DONE=1 two cycles after START; COUNT=0.
- pix_gnt random 50% duty: each address is held stable until granted, with no skips or duplicates. START written mid-fill is ignored. Changing COLOUR mid-fill does not change pix_data.
- IRQ_EN=1: irq rises with DONE; writing STATUS=0x2 clears DONE and irq the next cycle. Reset asserted during FILL: pix_req=0 and all registers 0 after one edge.
